// File: rtl/exec_pkg.sv
// Shared opcode encodings, execute FSM states and counter sizing for execute_unit.
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Iteration counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/execute_unit_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle; busy for WIDTH cycles after start.
// done is combinational on the final iteration and product_lo then carries the finished low WIDTH bits.
module shift_add_multiplier
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;

  assign acc_next   = acc + (b[0] ? a : '0);
  assign done       = busy && (count == CW'(WIDTH - 1));
  assign product_lo = acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= 1'b0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      a     <= mcand;
      b     <= mplier;
      acc   <= '0;
      count <= '0;
    end else if (busy) begin
      acc   <= acc_next;
      a     <= a << 1;
      b     <= b >> 1;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage driving the register-file write port; ALU results one cycle after accept.
// EXECUTE_MUL_EN adds a WIDTH-cycle multiplier that drops in_ready; otherwise opcode 111 pulses illegal_op.
module execute_unit
  import exec_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [WIDTH-1:0]      WriteData,
  output logic                  illegal_op
);

  logic             accept;
  logic [WIDTH-1:0] alu_res;

  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = op_a << op_b[3:0];
      OP_SHR:  alu_res = op_a >> op_b[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXECUTE_MUL_EN
  state_t                state;
  logic [REG_ADDR_W-1:0] mul_dest;
  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;
  logic [WIDTH-1:0]      mul_prod;

  assign mul_start = accept && (opcode == OP_MUL);
  assign in_ready  = (state == ST_IDLE) && !mul_busy;

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock      (clock),
    .reset      (reset),
    .start      (mul_start),
    .mcand      (op_a),
    .mplier     (op_b),
    .busy       (mul_busy),
    .done       (mul_done),
    .product_lo (mul_prod)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      mul_dest   <= '0;
      RegWrite   <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      illegal_op <= 1'b0;
    end else begin
      RegWrite   <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state    <= ST_MUL;
            mul_dest <= dest;
          end else if (accept) begin
            RegWrite  <= 1'b1;
            WriteReg  <= dest;
            WriteData <= alu_res;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            RegWrite  <= 1'b1;
            WriteReg  <= mul_dest;
            WriteData <= mul_prod;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      illegal_op <= 1'b0;
    end else begin
      RegWrite   <= 1'b0;
      illegal_op <= 1'b0;
      if (accept) begin
        // Unsupported opcode is consumed but leaves the write port untouched.
        if (opcode == OP_MUL) begin
          illegal_op <= 1'b1;
        end else begin
          RegWrite  <= 1'b1;
          WriteReg  <= dest;
          WriteData <= alu_res;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit; covers the multiplier only when EXECUTE_MUL_EN is defined.
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [2:0]  dest;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        illegal_op;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  execute_unit #(.WIDTH(16), .REG_ADDR_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .dest       (dest),
    .op_a       (op_a),
    .op_b       (op_b),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .illegal_op (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] d, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    opcode   = op;
    dest     = d;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = 3'd0;
    dest     = 3'd0;
    op_a     = 16'h0;
    op_b     = 16'h0;
    step();
    step();
    check("reset_regwrite", RegWrite, 0);
    check("reset_writereg", WriteReg, 0);
    check("reset_writedata", WriteData, 0);
    check("reset_illegal", illegal_op, 0);
    check("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    step();
    check("idle_regwrite", RegWrite, 0);

    // ADD wraps modulo 2^16
    drive(3'b000, 3'd3, 16'hFFFF, 16'h0001);
    step();
    in_valid = 1'b0;
    check("add_regwrite", RegWrite, 1);
    check("add_writereg", WriteReg, 3);
    check("add_writedata", WriteData, 16'h0000);

    // back-to-back SUB then SHR
    drive(3'b001, 3'd1, 16'h0005, 16'h0007);
    step();
    check("sub_regwrite", RegWrite, 1);
    check("sub_writereg", WriteReg, 1);
    check("sub_writedata", WriteData, 16'hFFFE);
    drive(3'b110, 3'd2, 16'h8000, 16'h000F);
    step();
    in_valid = 1'b0;
    op_a     = 16'hDEAD;
    check("shr_regwrite", RegWrite, 1);
    check("shr_writereg", WriteReg, 2);
    check("shr_writedata", WriteData, 16'h0001);
    step();
    check("idle2_regwrite", RegWrite, 0);
    check("hold_writereg", WriteReg, 2);
    check("hold_writedata", WriteData, 16'h0001);

    // logic ops and shifts, back to back
    drive(3'b010, 3'd4, 16'hF0F0, 16'h3C3C);
    step();
    check("and_writedata", WriteData, 16'h3030);
    drive(3'b011, 3'd5, 16'hF0F0, 16'h3C3C);
    step();
    check("or_writedata", WriteData, 16'hFCFC);
    check("or_writereg", WriteReg, 5);
    drive(3'b100, 3'd6, 16'hF0F0, 16'h3C3C);
    step();
    check("xor_writedata", WriteData, 16'hCCCC);
    drive(3'b101, 3'd5, 16'h1234, 16'hFFF0);
    step();
    check("shl0_writedata", WriteData, 16'h1234);
    drive(3'b101, 3'd5, 16'h8421, 16'h0004);
    step();
    check("shl4_writedata", WriteData, 16'h4210);
    check("shl4_regwrite", RegWrite, 1);
    in_valid = 1'b0;
    step();

`ifdef EXECUTE_MUL_EN
    // MUL 0xFFFF*0xFFFF -> low half 0x0001, upstream stalled for 16 cycles
    drive(3'b111, 3'd7, 16'hFFFF, 16'hFFFF);
    step();
    for (int i = 1; i <= 16; i++) begin
      drive(3'b000, 3'd0, 16'h1111, 16'h2222);
      in_valid = (i % 2 == 1) && (i != 16);
      check($sformatf("mul_stall_ready_%0d", i), in_ready, 0);
      check($sformatf("mul_stall_regwrite_%0d", i), RegWrite, 0);
      step();
    end
    in_valid = 1'b0;
    check("mul_regwrite", RegWrite, 1);
    check("mul_writereg", WriteReg, 7);
    check("mul_writedata", WriteData, 16'h0001);
    check("mul_ready_back", in_ready, 1);
    step();
    check("mul_after_regwrite", RegWrite, 0);

    drive(3'b111, 3'd2, 16'h0003, 16'h0005);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("mul15_writedata", WriteData, 16'h000F);
    check("mul15_writereg", WriteReg, 2);
    check("mul15_regwrite", RegWrite, 1);

    // reset at accept+8 aborts the multiply
    drive(3'b111, 3'd6, 16'h0003, 16'h0005);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_regwrite", RegWrite, 0);
    check("abort_writereg", WriteReg, 0);
    check("abort_writedata", WriteData, 0);
    check("abort_illegal", illegal_op, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("abort_no_write_%0d", i), RegWrite, 0);
    end
`else
    // opcode 111 is rejected as illegal
    drive(3'b111, 3'd6, 16'h0003, 16'h0005);
    step();
    check("illegal_pulse", illegal_op, 1);
    check("illegal_regwrite", RegWrite, 0);
    check("illegal_ready", in_ready, 1);
    check("illegal_holds_data", WriteData, 16'h4210);
    drive(3'b000, 3'd0, 16'h0002, 16'h0002);
    step();
    in_valid = 1'b0;
    check("post_illegal_clear", illegal_op, 0);
    check("post_illegal_regwrite", RegWrite, 1);
    check("post_illegal_writedata", WriteData, 16'h0004);
    check("post_illegal_writereg", WriteReg, 0);
    step();
    check("post_illegal_idle", RegWrite, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
